// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: opcode map and controller state type.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_EQ  = 4'd4;
    localparam logic [3:0] OP_GT  = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_SHL = 4'd10;
    localparam logic [3:0] OP_SHR = 4'd11;

    typedef enum logic {
        IDLE,
        ITER
    } state_t;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath.
// One step per cycle for WIDTH cycles after load; outputs show the step in progress.
module seq_alu_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             op_is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             finish,
    output logic [WIDTH-1:0] res,
    output logic             overflow,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [2*WIDTH-1:0] step;

    // p holds {hi, lo}: {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : '0);
        diff = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        ge   = ~diff[WIDTH];
        if (div_q)
            step = {(ge ? diff[WIDTH-1:0] : p_q[2*WIDTH-2:WIDTH-1]),
                    p_q[WIDTH-2:0], ge};
        else
            step = {sum, p_q[WIDTH-1:1]};
    end

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        opnd_d = opnd_q;
        p_d    = p_q;
        if (load) begin
            cnt_d  = CW'(WIDTH);
            div_d  = op_is_div;
            opnd_d = b;
            p_d    = {{WIDTH{1'b0}}, a};
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            p_d   = step;
        end
    end

    assign finish   = (cnt_q == CW'(1));
    assign res      = step[WIDTH-1:0];
    assign overflow = !div_q && (step[2*WIDTH-1:WIDTH] != '0);
    assign dbz      = div_q && (opnd_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= 1'b0;
            opnd_q <= '0;
            p_q    <= '0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            opnd_q <= opnd_d;
            p_q    <= p_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/arith ops, iterative mul/div,
// registered result and status flags updated only on a done pulse.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       operation,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             div_by_zero
);
    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic             load;
    logic             it_finish;
    logic [WIDTH-1:0] it_res;
    logic             it_ovf;
    logic             it_dbz;

    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   sub_x;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             is_iter;

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .op_is_div (operation == OP_DIV),
        .a         (a),
        .b         (b),
        .finish    (it_finish),
        .res       (it_res),
        .overflow  (it_ovf),
        .dbz       (it_dbz)
    );

    always_comb begin
        add_x   = {1'b0, a} + {1'b0, b};
        sub_x   = {1'b0, a} - {1'b0, b};
        shamt   = b[SW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        unique case (operation)
            OP_ADD: {alu_c, alu_res} = add_x;
            OP_SUB: {alu_c, alu_res} = sub_x;
            OP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, a == b};
            OP_GT:  alu_res = {{(WIDTH-1){1'b0}}, a > b};
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHL: alu_res = a << shamt;
            OP_SHR: alu_res = a >> shamt;
            default: alu_res = '0;
        endcase
    end

    assign is_iter = (operation == OP_MUL) || (operation == OP_DIV);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && is_iter) begin
                    load    = 1'b1;
                    state_d = ITER;
                end else if (start) begin
                    result_d = alu_res;
                    zero_d   = (alu_res == '0);
                    carry_d  = alu_c;
                    dbz_d    = 1'b0;
                    done_d   = 1'b1;
                end
            end
            ITER: begin
                // last step: commit the step's output directly
                if (it_finish) begin
                    state_d  = IDLE;
                    result_d = it_res;
                    zero_d   = (it_res == '0);
                    carry_d  = it_ovf;
                    dbz_d    = it_dbz;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
        end
    end

    assign busy        = (state_q == ITER);
    assign done        = done_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign carry       = carry_q;
    assign div_by_zero = dbz_q;

endmodule
